// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fetch_pkg;

    localparam int XLEN = 32;

    // One buffered fetch: the returned instruction and the PC it was read from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Width of an occupancy counter able to represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with push, pop, clear and occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must not push when full or pop when empty.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset (clears storage too)
//   clear           drops all entries; wins over a same-cycle push
//   push, push_dat  write one entry at the tail
//   pop             advance the head
//   head_dat        head entry, or the last shown head value while empty
//   count           number of occupied entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2 * XLEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  hold_q, hold_d;

    // When empty, keep presenting whatever the head showed last so the
    // downstream data lines do not flicker with stale slot contents.
    assign head_dat = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;
    assign count    = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = head_dat;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues PC reads to a 1-cycle synchronous imem and queues {instr, pc} for decode.
// Latency: issue in N, entry written end of N+1, out_valid in N+2 (2 cycles fetch-to-decode).
// Backpressure: issue only while queued + in-flight < DEPTH; out_valid/out_ready handshake to decode.
//
// Ports:
//   CLK, reset              clock, synchronous active-high reset
//   pc / pc_enable          PC from upstream; enable advances it (issue) or loads redirect (flush)
//   imem_req/addr/rdata     synchronous instruction memory, data valid the cycle after req
//   flush                   redirect: drop queued entries and the in-flight response
//   out_valid/ready/instr/pc  decode handshake and head entry
//   count                   occupied entries
// Optional (macro FETCHQ_STATS_EN): stall_cycles, flush_drops saturating 32-bit counters.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [XLEN-1:0]          pc,
    output logic                     pc_enable,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [cnt_w(DEPTH)-1:0]  count
`ifdef FETCHQ_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [31:0]              flush_drops
`endif
);

    localparam int          CW      = cnt_w(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic              inflight_q, inflight_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credits_used;
    logic              issue;
    logic              push;
    logic              pop;
    logic              head_vld;
    fetch_entry_t      push_ent;
    fetch_entry_t      head_ent;

    always_comb begin
        // Every slot is either occupied or reserved by the response in flight,
        // so limiting their sum to DEPTH makes overflow impossible.
        credits_used = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
        issue        = !reset && !flush && (credits_used < DEPTH_C);
        // A flush kills the response returning this cycle.
        push         = inflight_q && !reset && !flush;
        head_vld     = (fifo_count != '0) && !reset && !flush;
        pop          = head_vld && out_ready;
        // The in-flight flag lives exactly one cycle; issue is already 0 on flush/reset.
        inflight_d   = issue;
        req_pc_d     = issue ? pc : req_pc_q;
        push_ent     = '{instr: imem_rdata, pc: req_pc_q};
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (CLK),
        .reset    (reset),
        .clear    (flush),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .count    (fifo_count)
    );

    assign imem_req  = issue;
    assign pc_enable = issue | flush;
    assign imem_addr = pc;
    assign out_valid = head_vld;
    // Outputs read 0 while reset is held, regardless of stored state.
    assign out_instr = reset ? '0 : head_ent.instr;
    assign out_pc    = reset ? '0 : head_ent.pc;
    assign count     = reset ? '0 : fifo_count;

`ifdef FETCHQ_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] drops_q, drops_d;
    logic [32:0] drops_sum;

    always_comb begin
        stall_d   = stall_q;
        drops_d   = drops_q;
        // Entries lost on a flush are the queued ones plus the in-flight response.
        drops_sum = {1'b0, drops_q} + 33'(credits_used);
        if (flush) begin
            drops_d = drops_sum[32] ? '1 : drops_sum[31:0];
        end else if (!issue && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            stall_q <= '0;
            drops_q <= '0;
        end else begin
            stall_q <= stall_d;
            drops_q <= drops_d;
        end
    end

    assign stall_cycles = reset ? '0 : stall_q;
    assign flush_drops  = reset ? '0 : drops_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, hand sequences and randomized
// traffic checked every cycle against a queue-based model of the fetch rules.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'd0;
    logic        pc_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;
    logic [31:0] load_val = 32'd0;
`ifdef FETCHQ_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_drops;
`endif

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .pc         (pc),
        .pc_enable  (pc_enable),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .count      (count)
`ifdef FETCHQ_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_drops  (flush_drops)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] f_instr(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Upstream PC: advances by 4 on enable, loads load_val on flush or reset.
    always @(posedge CLK) begin
        if (reset)          pc <= load_val;
        else if (pc_enable) pc <= flush ? load_val : pc + 32'd4;
    end

    // Synchronous memory; garbage on cycles with no request.
    always @(posedge CLK) begin
        imem_rdata <= imem_req ? f_instr(imem_addr) : $urandom();
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    bit          m_inf = 1'b0;
    logic [31:0] m_inf_pc = 32'd0;
    ent_t        m_last = '0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_drops = 32'd0;

    // Drive one cycle's inputs, compare all outputs with the model, advance the model.
    task automatic step(input logic r, input logic f, input logic rdy, input logic [31:0] tgt);
        int   occ;
        logic e_req, e_vld;
        ent_t disp;
        @(negedge CLK);
        reset = r; flush = f; out_ready = rdy; load_val = tgt;
        #1;
        occ   = mq.size() + int'(m_inf);
        e_req = !r && !f && (occ < DEPTH);
        e_vld = !r && !f && (mq.size() > 0);
        disp  = (mq.size() > 0) ? mq[0] : m_last;
        chk("imem_req", imem_req, e_req);
        chk("pc_enable", pc_enable, e_req | f);
        chk("imem_addr", imem_addr, pc);
        chk("out_valid", out_valid, e_vld);
        chk("count", count, r ? 0 : mq.size());
        chk("out_pc", out_pc, r ? 32'd0 : disp.pc);
        chk("out_instr", out_instr, r ? 32'd0 : disp.instr);
`ifdef FETCHQ_STATS_EN
        chk("stall_cycles", stall_cycles, r ? 32'd0 : m_stall);
        chk("flush_drops", flush_drops, r ? 32'd0 : m_drops);
`endif
        if (r) begin
            mq.delete(); m_inf = 1'b0; m_last = '0; m_stall = 0; m_drops = 0;
        end else begin
            m_last = disp;
            if (f) begin
                m_drops = (m_drops > 32'hFFFF_FFFF - 32'(occ)) ? 32'hFFFF_FFFF : m_drops + 32'(occ);
                mq.delete();
                m_inf = 1'b0;
            end else begin
                if (!e_req && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
                if (e_vld && rdy) void'(mq.pop_front());
                if (m_inf) mq.push_back('{instr: f_instr(m_inf_pc), pc: m_inf_pc});
                m_inf    = e_req;
                m_inf_pc = pc;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  ins;   // {reset, flush, out_ready}
        logic [31:0] tgt;   // redirect / reset PC presented upstream
        logic [1:0]  rv;    // expected {imem_req, out_valid}
        logic [2:0]  cnt;
        logic [31:0] opc;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] ins, input logic [31:0] tgt,
                                input logic [1:0] rv, input logic [2:0] cnt, input logic [31:0] opc);
        vec_t v;
        v.ins = ins; v.tgt = tgt; v.rv = rv; v.cnt = cnt; v.opc = opc;
        return v;
    endfunction

    vec_t tbl[29];

    initial begin
        int          guard;
        logic [31:0] base, s0, d0;

        tbl[0]  = mk(3'b101, 32'h0,   2'b00, 3'd0, 32'h0);   // reset
        tbl[1]  = mk(3'b101, 32'h0,   2'b00, 3'd0, 32'h0);
        tbl[2]  = mk(3'b001, 32'h0,   2'b10, 3'd0, 32'h0);   // first issue, outputs still 0
        tbl[3]  = mk(3'b001, 32'h0,   2'b10, 3'd0, 32'h0);
        tbl[4]  = mk(3'b001, 32'h0,   2'b11, 3'd1, 32'h0);   // 2 cycles after first issue
        tbl[5]  = mk(3'b001, 32'h0,   2'b11, 3'd1, 32'h4);
        tbl[6]  = mk(3'b001, 32'h0,   2'b11, 3'd1, 32'h8);
        tbl[7]  = mk(3'b000, 32'h0,   2'b11, 3'd1, 32'hC);   // decode stalls
        tbl[8]  = mk(3'b000, 32'h0,   2'b11, 3'd2, 32'hC);
        tbl[9]  = mk(3'b000, 32'h0,   2'b01, 3'd3, 32'hC);   // 3 queued + 1 in flight: no issue
        tbl[10] = mk(3'b000, 32'h0,   2'b01, 3'd4, 32'hC);   // full
        tbl[11] = mk(3'b000, 32'h0,   2'b01, 3'd4, 32'hC);
        tbl[12] = mk(3'b001, 32'h0,   2'b01, 3'd4, 32'hC);   // one pop
        tbl[13] = mk(3'b000, 32'h0,   2'b11, 3'd3, 32'h10);  // one issue refills
        tbl[14] = mk(3'b000, 32'h0,   2'b01, 3'd3, 32'h10);
        tbl[15] = mk(3'b000, 32'h0,   2'b01, 3'd4, 32'h10);
        tbl[16] = mk(3'b001, 32'h0,   2'b01, 3'd4, 32'h10);
        tbl[17] = mk(3'b000, 32'h0,   2'b11, 3'd3, 32'h14);  // 3 queued, issue -> 1 in flight
        tbl[18] = mk(3'b011, 32'h100, 2'b00, 3'd3, 32'h14);  // flush F, no pop despite ready
        tbl[19] = mk(3'b001, 32'h0,   2'b10, 3'd0, 32'h14);  // F+1: count 0, issue 0x100
        tbl[20] = mk(3'b001, 32'h0,   2'b10, 3'd0, 32'h14);  // stale response not written
        tbl[21] = mk(3'b001, 32'h0,   2'b11, 3'd1, 32'h100); // F+3
        tbl[22] = mk(3'b001, 32'h0,   2'b11, 3'd1, 32'h104);
        tbl[23] = mk(3'b000, 32'h0,   2'b11, 3'd1, 32'h108);
        tbl[24] = mk(3'b000, 32'h0,   2'b11, 3'd2, 32'h108);
        tbl[25] = mk(3'b100, 32'h200, 2'b00, 3'd0, 32'h0);   // reset with count 3
        tbl[26] = mk(3'b001, 32'h200, 2'b10, 3'd0, 32'h0);   // all outputs 0 after deassert
        tbl[27] = mk(3'b001, 32'h0,   2'b10, 3'd0, 32'h0);
        tbl[28] = mk(3'b001, 32'h0,   2'b11, 3'd1, 32'h200); // post-reset pc

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].ins[2], tbl[i].ins[1], tbl[i].ins[0], tbl[i].tgt);
            chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].rv[1]);
            chk($sformatf("tbl%0d_vld", i), out_valid, tbl[i].rv[0]);
            chk($sformatf("tbl%0d_cnt", i), count, tbl[i].cnt);
            chk($sformatf("tbl%0d_opc", i), out_pc, tbl[i].opc);
            if (tbl[i].rv[0]) chk($sformatf("tbl%0d_instr", i), out_instr, f_instr(tbl[i].opc));
            if (tbl[i].ins[2]) chk($sformatf("tbl%0d_instr0", i), out_instr, 32'd0);
        end

        // Push and pop together at count 2, order kept across several pointer wraps.
        step(1'b0, 1'b0, 1'b0, 32'd0);
        base = mq[0].pc;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'd0);
            chk($sformatf("wrap%0d_cnt", i), count, 3'd2);
            chk($sformatf("wrap%0d_pc", i), out_pc, base + 32'(4 * i));
        end

        // Stall at full for 10 cycles, then flush the 4 entries.
        guard = 0;
        while ((mq.size() != DEPTH || m_inf) && guard < 12) begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            guard++;
        end
        chk("fill_reached", ((mq.size() == DEPTH) && !m_inf), 1'b1);
        s0 = m_stall;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
        d0 = m_drops;
        step(1'b0, 1'b1, 1'b0, 32'h400);
        chk("full_cnt", count, 3'd4);
`ifdef FETCHQ_STATS_EN
        chk("stall_plus10", stall_cycles, s0 + 32'd10);
`endif
        step(1'b0, 1'b0, 1'b1, 32'd0);
        chk("flushed_cnt", count, 3'd0);
        chk("flushed_pc", pc, 32'h400);
`ifdef FETCHQ_STATS_EN
        chk("drops_plus4", flush_drops, d0 + 32'd4);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 60, $urandom() & 32'hFFFF_FFFC);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch stage that sits directly downstream of the dual-function program counter. It takes the current PC and issues a read to a synchronous instruction memory with one-cycle latency. It buffers each returned instruction with its PC in a small FIFO for decode, using a valid/ready handshake. It also drives the PC's enable so the PC advances only when a fetch is actually issued, and it supports a flush for PC redirects.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2
- XLEN, 32: PC and instruction width

- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc  in  XLEN  current PC value from the program counter
- pc_enable  out  1  enable to the program counter
- imem_req  out  1  instruction memory read strobe
- imem_addr  out  XLEN  read address; equals pc, combinational
- imem_rdata  in  XLEN  read data, valid the cycle after imem_req
- flush  in  1  redirect: discard queued and in-flight fetches
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts head entry
- out_instr  out  XLEN  head instruction
- out_pc  out  XLEN  PC of head instruction
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Credit rule:
  - imem_req = !reset && !flush && (count + inflight) < DEPTH.
  - inflight is a 1-bit register set when imem_req fires.
- pc_enable = imem_req | flush. The PC advances on every issue; during flush it loads the redirect target that upstream presents with load mode.
- Request tagging: on issue, pc is latched into req_pc.
- Push: in the cycle after issue, if inflight is set and not killed, {imem_rdata, req_pc} is written at the tail.
- Pop: when out_valid && out_ready, the head advances. Push and pop in the same cycle leave count unchanged.
- Full: no issue when count + inflight == DEPTH. Overflow is impossible by construction.
- Empty: out_valid = 0. out_instr and out_pc hold the last head value and are 0 after reset.
- Flush, in the flush cycle:
  - count → 0.
  - inflight is killed, so the response arriving next cycle is discarded.
  - out_valid is forced 0 and no pop occurs.
  - No issue occurs.
- Flush while a response is returning: that response is dropped.
- Pointers wrap modulo DEPTH.
- Reset:
  - Same as flush, plus pointers, req_pc and any counters are cleared.
  - All outputs read 0 during reset and in the cycle after it deasserts. imem_req may rise in the first post-reset cycle.

## Timing
- Issue in cycle N: the entry is written at the end of N+1 and out_valid is high in N+2. Fetch-to-decode latency is 2 cycles.
- Steady state is one issue per cycle while decode accepts every cycle.
- A flush in cycle F makes the first fetch of the new target issue in F+1; its instruction is visible in F+3.
- out_* come from registered storage; there is no combinational path from imem_rdata to out_*.

## Configuration
- FETCHQ_STATS_EN defined:
  - Adds output stall_cycles (32-bit): counts cycles where imem_req = 0 because of the credit rule, excluding flush and reset cycles.
  - Adds output flush_drops (32-bit): counts discarded entries and in-flight responses.
  - Both counters saturate at all-ones and clear on reset.
- FETCHQ_STATS_EN undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Shared package fetch_pkg holds:
  - XLEN
  - The fetch entry struct {instr, pc}
  - The count-width function
- One sub-module, fetch_fifo:
  - Parameterised DEPTH/width storage with push, pop, clear and count.
  - Clear has priority over push.
- Credit, inflight and flush logic stay in the top level.

## Test plan
- Reset, then pc = 0, 4, 8… with out_ready = 1 → one issue per cycle; out_pc sequence 0, 4, 8 starting 2 cycles after the first issue; count stays ≤ 2.
- out_ready = 0 with DEPTH = 4 → exactly 4 issues; imem_req and pc_enable then drop; count = 4. One pop → one issue, count returns to 4.
- Flush with 3 queued entries and 1 in flight, and upstream loading pc = 0x100 → count = 0 next cycle; the stale response is not written; the first output is out_pc = 0x100 at F+3.
- Push and pop in the same cycle at count = 2 → count stays 2; order preserved across pointer wrap over 12 entries.
- Reset asserted mid-stream with count = 3 → all outputs 0 in the following cycle; the next data has out_pc equal to the post-reset pc.
- With FETCHQ_STATS_EN and decode stalled 10 cycles at full → stall_cycles increments by 10, then a flush of 4 entries → flush_drops increments by 4.
